// File: rtl/dctq_rle_encoder.sv
// Ping-pong 8x8 coefficient buffer, zigzag rescan and (run, level) token emitter.
// Optional feature macro: DCTQ_RLE_ZRL_EN limits runs to 15 by inserting (15,0) ZRL tokens.
module dctq_rle_encoder #(
    parameter int COEF_W = 9,
    parameter int RUN_W  = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dctq_valid,
    input  logic [COEF_W-1:0] dctq1,
    input  logic [5:0]        addr,
    output logic              hold,
    output logic              rle_valid,
    input  logic              rle_ready,
    output logic [RUN_W-1:0]  rle_run,
    output logic [COEF_W-1:0] rle_level,
    output logic              rle_last,
    output logic              overflow
);

    // Token stream: a token is transferred on any rising edge where rle_valid && rle_ready;
    // while rle_valid && !rle_ready the token fields are held and the scan does not advance.

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
`ifdef DCTQ_RLE_ZRL_EN
        S_ZRL,
`endif
        S_EOB,
        S_DONE
    } state_t;

    localparam logic [5:0] ZZ [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    logic [COEF_W-1:0] mem [0:127];
    logic [1:0]        full;
    logic              wr_bank;
    logic              rd_bank;
    logic [5:0]        k;
    logic [RUN_W-1:0]  run;
    state_t            state;
    logic              wr_en;
    logic              can_load;
    logic [COEF_W-1:0] coef;

    assign hold     = full[wr_bank];
    assign wr_en    = dctq_valid && !hold;
    assign can_load = !rle_valid || rle_ready;
    assign coef     = mem[{rd_bank, ZZ[k]}];

    // Buffer contents need no reset: a bank is only read after its full flag is set.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[{wr_bank, addr}] <= dctq1;
        end
    end

    // Full flags are shared by writer (set) and reader (clear); they never target the same bank.
    always_ff @(posedge clk) begin
        if (reset) begin
            full     <= 2'b00;
            wr_bank  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (state == S_DONE) begin
                full[rd_bank] <= 1'b0;
            end
            if (wr_en && addr == 6'd63) begin
                full[wr_bank] <= 1'b1;
                wr_bank       <= ~wr_bank;
            end
            if (dctq_valid && hold) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            rd_bank   <= 1'b0;
            k         <= 6'd0;
            run       <= '0;
            rle_valid <= 1'b0;
            rle_run   <= '0;
            rle_level <= '0;
            rle_last  <= 1'b0;
        end else begin
            if (rle_valid && rle_ready) begin
                rle_valid <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    if (full[rd_bank]) begin
                        state <= S_SCAN;
                        k     <= 6'd0;
                        run   <= '0;
                    end
                end
                S_SCAN: begin
                    if (can_load) begin
                        if (k == 6'd0) begin
                            rle_valid <= 1'b1;
                            rle_run   <= '0;
                            rle_level <= coef;
                            rle_last  <= 1'b0;
                            k         <= k + 6'd1;
                        end
`ifdef DCTQ_RLE_ZRL_EN
                        else if (coef != '0 && run >= RUN_W'(16)) begin
                            state <= S_ZRL;
                        end
`endif
                        else if (coef != '0) begin
                            rle_valid <= 1'b1;
                            rle_run   <= run;
                            rle_level <= coef;
                            rle_last  <= (k == 6'd63);
                            run       <= '0;
                            if (k == 6'd63) begin
                                state <= S_DONE;
                            end else begin
                                k <= k + 6'd1;
                            end
                        end else if (k == 6'd63) begin
                            state <= S_EOB;
                        end else begin
                            run <= run + RUN_W'(1);
                            k   <= k + 6'd1;
                        end
                    end
                end
`ifdef DCTQ_RLE_ZRL_EN
                // k stays on the pending nonzero; SCAN re-reads it once run drops below 16.
                S_ZRL: begin
                    if (can_load) begin
                        rle_valid <= 1'b1;
                        rle_run   <= RUN_W'(15);
                        rle_level <= '0;
                        rle_last  <= 1'b0;
                        run       <= run - RUN_W'(16);
                        if (run < RUN_W'(32)) begin
                            state <= S_SCAN;
                        end
                    end
                end
`endif
                S_EOB: begin
                    if (can_load) begin
                        rle_valid <= 1'b1;
                        rle_run   <= '0;
                        rle_level <= '0;
                        rle_last  <= 1'b1;
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    rd_bank <= ~rd_bank;
                    if (full[~rd_bank]) begin
                        state <= S_SCAN;
                        k     <= 6'd0;
                        run   <= '0;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dctq_rle_encoder.sv
// Directed bench for dctq_rle_encoder: block-level token model, per-cycle compare, literal pins.
module tb_dctq_rle_encoder;

    logic       clk = 1'b0;
    logic       reset;
    logic       dctq_valid;
    logic [8:0] dctq1;
    logic [5:0] addr;
    logic       hold;
    logic       rle_valid;
    logic       rle_ready;
    logic [5:0] rle_run;
    logic [8:0] rle_level;
    logic       rle_last;
    logic       overflow;

    int          n_checks = 0;
    int          n_fail = 0;
    int          tok_cnt = 0;
    logic [15:0] exp_q[$];
    logic [8:0]  blk [64];
    int          zz [64];
    logic        prev_stall = 1'b0;
    logic [15:0] prev_tok;
    logic [15:0] cmp_cur;
    logic [15:0] cmp_exp;

    always #5 clk = ~clk;

    dctq_rle_encoder dut (
        .clk(clk), .reset(reset), .dctq_valid(dctq_valid), .dctq1(dctq1), .addr(addr),
        .hold(hold), .rle_valid(rle_valid), .rle_ready(rle_ready), .rle_run(rle_run),
        .rle_level(rle_level), .rle_last(rle_last), .overflow(overflow)
    );

    function automatic logic [15:0] tok(input int run, input logic [8:0] lvl, input logic last);
        logic [5:0] r;
        r = run[5:0];
        return {r, lvl, last};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Zigzag order derived by walking the anti-diagonals, alternating direction.
    function automatic void build_zz();
        int n;
        n = 0;
        for (int s = 0; s < 15; s++) begin
            int lo;
            int hi;
            lo = (s > 7) ? s - 7 : 0;
            hi = (s < 7) ? s : 7;
            if (s % 2 == 0) begin
                for (int r = hi; r >= lo; r--) begin zz[n] = r * 8 + (s - r); n++; end
            end else begin
                for (int r = lo; r <= hi; r++) begin zz[n] = r * 8 + (s - r); n++; end
            end
        end
    endfunction

    function automatic void clear_blk();
        for (int a = 0; a < 64; a++) blk[a] = 9'd0;
    endfunction

    // Token list for the current block, straight from the run-length rules.
    function automatic void model_block();
        int run;
        run = 0;
        exp_q.push_back(tok(0, blk[zz[0]], 1'b0));
        for (int k = 1; k < 64; k++) begin
            logic [8:0] v;
            v = blk[zz[k]];
            if (v == 9'd0) begin
                if (k == 63) exp_q.push_back(tok(0, 9'd0, 1'b1));
                else run++;
            end else begin
`ifdef DCTQ_RLE_ZRL_EN
                while (run >= 16) begin
                    exp_q.push_back(tok(15, 9'd0, 1'b0));
                    run -= 16;
                end
`endif
                exp_q.push_back(tok(run, v, k == 63));
                run = 0;
            end
        end
    endfunction

    task automatic write_block();
        for (int a = 0; a < 64; a++) begin
            int w;
            w = 0;
            while (hold && w < 2000) begin
                @(posedge clk); #1;
                w++;
            end
            if (hold) check("hold_wait_timeout", 32'(hold), 0);
            dctq_valid = 1'b1;
            addr = a[5:0];
            dctq1 = blk[a];
            @(posedge clk); #1;
        end
        dctq_valid = 1'b0;
    endtask

    task automatic wait_valid();
        int w;
        w = 0;
        while (!rle_valid && w < 500) begin
            @(posedge clk); #1;
            w++;
        end
        check("valid_timeout", 32'(rle_valid), 1);
    endtask

    task automatic wait_drain();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 3000) begin
            @(posedge clk); #1;
            w++;
        end
        check("drain_left", exp_q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
        check("idle_valid", 32'(rle_valid), 0);
    endtask

    task automatic check_outputs_zero(input string tag);
        @(negedge clk);
        check({tag, "_hold"}, 32'(hold), 0);
        check({tag, "_valid"}, 32'(rle_valid), 0);
        check({tag, "_run"}, 32'(rle_run), 0);
        check({tag, "_level"}, 32'(rle_level), 0);
        check({tag, "_last"}, 32'(rle_last), 0);
        check({tag, "_overflow"}, 32'(overflow), 0);
    endtask

    // Per-cycle compare: accepted tokens against the model, stalled tokens against themselves.
    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            cmp_cur = {rle_run, rle_level, rle_last};
            if (prev_stall) begin
                check("stall_valid", 32'(rle_valid), 1);
                check("stall_fields", 32'(cmp_cur), 32'(prev_tok));
            end
            if (rle_valid && rle_ready) begin
                tok_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_token", 32'(cmp_cur), 32'hFFFF_FFFF);
                end else begin
                    cmp_exp = exp_q.pop_front();
                    check("token", 32'(cmp_cur), 32'(cmp_exp));
                end
            end
            prev_stall = rle_valid && !rle_ready;
            prev_tok = cmp_cur;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        build_zz();
        reset = 1'b1;
        dctq_valid = 1'b0;
        dctq1 = 9'd0;
        addr = 6'd0;
        rle_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check_outputs_zero("reset");

        check("zz_k2", zz[2], 8);
        check("zz_k3", zz[3], 16);
        check("zz_k4", zz[4], 9);
        check("zz_k63", zz[63], 63);

        // All-zero block: DC then EOB, with the documented latency.
        clear_blk();
        model_block();
        check("pin1_size", exp_q.size(), 2);
        check("pin1_t0", 32'(exp_q[0]), 32'(tok(0, 9'd0, 1'b0)));
        check("pin1_t1", 32'(exp_q[1]), 32'(tok(0, 9'd0, 1'b1)));
        tok_cnt = 0;
        write_block();
        @(negedge clk);
        check("lat_t0", 32'(rle_valid), 0);
        @(negedge clk);
        check("lat_t1", 32'(rle_valid), 0);
        @(negedge clk);
        check("lat_t2", 32'(rle_valid), 1);
        wait_drain();
        check("zero_blk_tokens", tok_cnt, 2);

        // DC plus one negative AC, raw bits preserved.
        clear_blk();
        blk[0] = 9'd5;
        blk[1] = 9'h1FD;
        model_block();
        check("pin2_size", exp_q.size(), 3);
        check("pin2_t1", 32'(exp_q[1]), 32'(tok(0, 9'h1FD, 1'b0)));
        check("pin2_t2", 32'(exp_q[2]), 32'(tok(0, 9'd0, 1'b1)));
        write_block();
        wait_drain();

        // Only the last coefficient nonzero: longest run.
        clear_blk();
        blk[63] = 9'd7;
        model_block();
`ifdef DCTQ_RLE_ZRL_EN
        check("pin3_size", exp_q.size(), 5);
        check("pin3_zrl", 32'(exp_q[3]), 32'(tok(15, 9'd0, 1'b0)));
        check("pin3_last", 32'(exp_q[4]), 32'(tok(14, 9'd7, 1'b1)));
`else
        check("pin3_size", exp_q.size(), 2);
        check("pin3_last", 32'(exp_q[1]), 32'(tok(62, 9'd7, 1'b1)));
`endif
        write_block();
        wait_drain();

        // Ten-cycle stall on the first token of a block.
        rle_ready = 1'b0;
        clear_blk();
        blk[0] = 9'd3;
        blk[9] = 9'h100;
        blk[63] = 9'd1;
        model_block();
        write_block();
        wait_valid();
        repeat (10) @(posedge clk);
        #1 rle_ready = 1'b1;
        wait_drain();

        // Three blocks against a stalled consumer; a write during hold must be dropped.
        rle_ready = 1'b0;
        clear_blk();
        blk[0] = 9'd1;
        model_block();
        write_block();
        clear_blk();
        blk[0] = 9'd2;
        blk[5] = 9'd4;
        model_block();
        write_block();
        check("hold_rise", 32'(hold), 1);
        check("overflow_pre", 32'(overflow), 0);
        dctq_valid = 1'b1;
        addr = 6'd2;
        dctq1 = 9'h055;
        @(posedge clk); #1;
        dctq_valid = 1'b0;
        check("overflow_set", 32'(overflow), 1);
        repeat (5) @(posedge clk);
        #1;
        check("hold_stays", 32'(hold), 1);
        rle_ready = 1'b1;
        begin
            int w;
            w = 0;
            while (hold && w < 500) begin
                @(posedge clk); #1;
                w++;
            end
        end
        check("hold_fall", 32'(hold), 0);
        clear_blk();
        blk[0] = 9'h1FF;
        blk[63] = 9'h1FF;
        model_block();
        write_block();
        wait_drain();
        check("overflow_sticky", 32'(overflow), 1);

        // Reset in the middle of a scan, then a normal block.
        clear_blk();
        for (int a = 0; a < 64; a++) blk[a] = (a % 3 == 0) ? 9'(a + 1) : 9'd0;
        model_block();
        write_block();
        wait_valid();
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        exp_q.delete();
        check_outputs_zero("midscan_reset");
        clear_blk();
        blk[0] = 9'd5;
        blk[1] = 9'h1FD;
        model_block();
        tok_cnt = 0;
        write_block();
        wait_drain();
        check("post_reset_tokens", tok_cnt, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
